// File: rtl/core_stage_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// core_stage_sequencer_pkg
//   Shared definitions for the RockWave core stage sequencer: the sequencer
//   state encoding (SEQ_IDLE..SEQ_ERROR), its width SEQ_STATE_W, and a helper
//   that tells whether a state counts as "busy".
//   No ports (package).
// -----------------------------------------------------------------------------
package core_stage_sequencer_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_FETCH     = 3'd1,
    SEQ_DECODE    = 3'd2,
    SEQ_EXECUTE   = 3'd3,
    SEQ_MEMORY    = 3'd4,
    SEQ_WRITEBACK = 3'd5,
    SEQ_ERROR     = 3'd6
  } seq_state_e;

  // Busy means an instruction is in flight; IDLE, ERROR and any unused code are not busy.
  function automatic logic seq_is_busy(input seq_state_e s);
    logic v;
    case (s)
      SEQ_FETCH, SEQ_DECODE, SEQ_EXECUTE, SEQ_MEMORY, SEQ_WRITEBACK: v = 1'b1;
      default:                                                       v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/core_stage_sequencer_wait_timer.sv
// -----------------------------------------------------------------------------
// core_stage_sequencer_wait_timer
//   Memory wait counter shared by the FETCH and MEMORY states. It is held at
//   zero while i_clr is high and counts cycles in which i_inc is high.
//   o_timeout flags the last permitted wait cycle: if the waited-for ready is
//   still low in that cycle, the sequencer goes to ERROR.
//   Parameters: LIMIT - number of wait cycles allowed; 0 disables the timeout.
//   Ports:
//     i_clk      in  core clock
//     i_rst      in  synchronous reset, active-high
//     i_clr      in  clear counter to zero
//     i_inc      in  count one held-wait cycle
//     o_timeout  out this is the final allowed wait cycle
// -----------------------------------------------------------------------------
module core_stage_sequencer_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);

  localparam int              CW   = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0]   LAST = CW'((LIMIT > 0) ? (LIMIT - 1) : 0);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter; cleared whenever the sequencer is outside a wait state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // The counter shows how many waits already elapsed, so LIMIT-1 marks the last one.
  assign o_timeout = (LIMIT != 0) && (r_cnt == LAST);

endmodule

// File: rtl/core_stage_sequencer.sv
// -----------------------------------------------------------------------------
// core_stage_sequencer
//   Multi-cycle stage sequencer for the RockWave core. Steps one instruction
//   through FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK and drives one
//   stage FF enable per stage. It waits on memory ready, times out stalled bus
//   accesses into a sticky ERROR state and honours halt requests at WRITEBACK.
//   Optional feature macro: CORE_SEQ_PERF_EN (adds cycle/instret counters;
//   when undefined both counter ports are tied to zero).
//   Parameters: MEM_TIMEOUT (wait cycles before bus error, 0 = off),
//               CNT_W (performance counter width).
//   Ports:
//     i_clk, i_rst                  clock, synchronous active-high reset
//     i_run                         start execution from IDLE
//     i_halt_req                    stop after the current instruction retires
//     i_imem_ready, i_dmem_ready    instruction / data memory ready
//     i_mem_access                  instruction is LOAD/STORE (valid in EXECUTE)
//     o_fetch_en .. o_writeback_en  per-stage FF enables
//     o_busy                        state is neither IDLE nor ERROR
//     o_bus_err                     sticky timeout flag
//     o_cycle_cnt, o_instret_cnt    performance counters
// -----------------------------------------------------------------------------
module core_stage_sequencer
  import core_stage_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_halt_req,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  input  logic             i_mem_access,
  output logic             o_fetch_en,
  output logic             o_decode_en,
  output logic             o_execute_en,
  output logic             o_memaccess_en,
  output logic             o_writeback_en,
  output logic             o_busy,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt
);

  seq_state_e r_state;
  seq_state_e w_state_nxt;
  logic       r_halt;
  logic       w_halt_pend;
  logic       w_tmr_clr;
  logic       w_tmr_inc;
  logic       w_tmr_timeout;
  logic       r_fetch_en;
  logic       r_decode_en;
  logic       r_execute_en;
  logic       r_memaccess_en;
  logic       r_writeback_en;
  logic       r_busy;
  logic       r_bus_err;

  // FETCH and MEMORY are never entered from each other, so holding the timer
  // clear in every other state guarantees it starts at zero on entry.
  assign w_tmr_clr = (r_state != SEQ_FETCH) && (r_state != SEQ_MEMORY);
  assign w_tmr_inc = ((r_state == SEQ_FETCH)  && !i_imem_ready) ||
                     ((r_state == SEQ_MEMORY) && !i_dmem_ready);

  core_stage_sequencer_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_tmr_clr),
    .i_inc     (w_tmr_inc),
    .o_timeout (w_tmr_timeout)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ready is tested before timeout so a late ready still wins.
  always_comb begin
    w_state_nxt = r_state;
    w_halt_pend = r_halt | i_halt_req;
    case (r_state)
      SEQ_IDLE: begin
        if (i_run) w_state_nxt = SEQ_FETCH;
        else       w_state_nxt = SEQ_IDLE;
      end
      SEQ_FETCH: begin
        if (i_imem_ready)       w_state_nxt = SEQ_DECODE;
        else if (w_tmr_timeout) w_state_nxt = SEQ_ERROR;
        else                    w_state_nxt = SEQ_FETCH;
      end
      SEQ_DECODE:  w_state_nxt = SEQ_EXECUTE;
      SEQ_EXECUTE: begin
        if (i_mem_access) w_state_nxt = SEQ_MEMORY;
        else              w_state_nxt = SEQ_WRITEBACK;
      end
      SEQ_MEMORY: begin
        if (i_dmem_ready)       w_state_nxt = SEQ_WRITEBACK;
        else if (w_tmr_timeout) w_state_nxt = SEQ_ERROR;
        else                    w_state_nxt = SEQ_MEMORY;
      end
      SEQ_WRITEBACK: begin
        if (w_halt_pend) w_state_nxt = SEQ_IDLE;
        else             w_state_nxt = SEQ_FETCH;
      end
      SEQ_ERROR: w_state_nxt = SEQ_ERROR;
      default:   w_state_nxt = SEQ_IDLE;
    endcase
  end

  // Halt latch: captured in any busy state, consumed by WRITEBACK.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_halt <= 1'b0;
    end else if (r_state == SEQ_WRITEBACK) begin
      r_halt <= 1'b0;
    end else if (seq_is_busy(r_state) && i_halt_req) begin
      r_halt <= 1'b1;
    end else begin
      r_halt <= r_halt;
    end
  end

  // Moore outputs registered from the next state so they are aligned with r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_en     <= 1'b0;
      r_decode_en    <= 1'b0;
      r_execute_en   <= 1'b0;
      r_memaccess_en <= 1'b0;
      r_writeback_en <= 1'b0;
      r_busy         <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      r_fetch_en     <= (w_state_nxt == SEQ_FETCH);
      r_decode_en    <= (w_state_nxt == SEQ_DECODE);
      r_execute_en   <= (w_state_nxt == SEQ_EXECUTE);
      r_memaccess_en <= (w_state_nxt == SEQ_MEMORY);
      r_writeback_en <= (w_state_nxt == SEQ_WRITEBACK);
      r_busy         <= seq_is_busy(w_state_nxt);
      r_bus_err      <= (w_state_nxt == SEQ_ERROR);
    end
  end

  assign o_fetch_en     = r_fetch_en;
  assign o_decode_en    = r_decode_en;
  assign o_execute_en   = r_execute_en;
  assign o_memaccess_en = r_memaccess_en;
  assign o_writeback_en = r_writeback_en;
  assign o_busy         = r_busy;
  assign o_bus_err      = r_bus_err;

`ifdef CORE_SEQ_PERF_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  // Performance counters: busy cycles and retired instructions, wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle_cnt   <= {CNT_W{1'b0}};
      r_instret_cnt <= {CNT_W{1'b0}};
    end else begin
      if (seq_is_busy(r_state)) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      else                      r_cycle_cnt <= r_cycle_cnt;
      if (r_state == SEQ_WRITEBACK) r_instret_cnt <= r_instret_cnt + CNT_W'(1);
      else                          r_instret_cnt <= r_instret_cnt;
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
`else
  assign o_cycle_cnt   = {CNT_W{1'b0}};
  assign o_instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_core_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_stage_sequencer
//   Directed, self-checking bench for core_stage_sequencer. Each step drives
//   inputs on the falling edge, pushes the outputs expected after the next
//   rising edge to a scoreboard queue, then pops and compares them 1 time unit
//   after that edge. Output vector order: {fetch, decode, execute, memaccess,
//   writeback, busy, bus_err}.
// -----------------------------------------------------------------------------
module tb_core_stage_sequencer;

  localparam int CNT_W = 32;

  localparam logic [6:0] E_IDLE = 7'b0000000;
  localparam logic [6:0] E_F    = 7'b1000010;
  localparam logic [6:0] E_D    = 7'b0100010;
  localparam logic [6:0] E_E    = 7'b0010010;
  localparam logic [6:0] E_M    = 7'b0001010;
  localparam logic [6:0] E_W    = 7'b0000110;
  localparam logic [6:0] E_ERR  = 7'b0000001;

  logic             clk;
  logic             rst;
  logic             run;
  logic             halt_req;
  logic             imem_ready;
  logic             dmem_ready;
  logic             mem_access;
  logic             fetch_en;
  logic             decode_en;
  logic             execute_en;
  logic             memaccess_en;
  logic             writeback_en;
  logic             busy;
  logic             bus_err;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  typedef struct {
    logic [6:0] exp;
    string      tag;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        checks   = 0;
  int        failures = 0;

  core_stage_sequencer #(
    .MEM_TIMEOUT (16),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_run          (run),
    .i_halt_req     (halt_req),
    .i_imem_ready   (imem_ready),
    .i_dmem_ready   (dmem_ready),
    .i_mem_access   (mem_access),
    .o_fetch_en     (fetch_en),
    .o_decode_en    (decode_en),
    .o_execute_en   (execute_en),
    .o_memaccess_en (memaccess_en),
    .o_writeback_en (writeback_en),
    .o_busy         (busy),
    .o_bus_err      (bus_err),
    .o_cycle_cnt    (cycle_cnt),
    .o_instret_cnt  (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock step: drive, enqueue expectation, pop and compare after the edge.
  task automatic step(input logic rst_v, input logic run_v, input logic halt_v,
                      input logic ir_v, input logic dr_v, input logic ma_v,
                      input logic [6:0] exp, input string tag);
    sb_entry_t  e;
    logic [6:0] obs;
    @(negedge clk);
    rst        = rst_v;
    run        = run_v;
    halt_req   = halt_v;
    imem_ready = ir_v;
    dmem_ready = dr_v;
    mem_access = ma_v;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    obs = {fetch_en, decode_en, execute_en, memaccess_en, writeback_en, busy, bus_err};
    checks++;
    assert (obs === e.exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask

  task automatic check_cnt(input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp,
                           input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [CNT_W-1:0] exp_cyc;
    logic [CNT_W-1:0] exp_ret;
    rst = 1'b1; run = 1'b0; halt_req = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; mem_access = 1'b0;

    // Reset for two cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "reset0");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_IDLE, "reset1");
    check_cnt(cycle_cnt,   {CNT_W{1'b0}}, "reset_cycle_cnt");
    check_cnt(instret_cnt, {CNT_W{1'b0}}, "reset_instret_cnt");

    // 1. ALU instruction, zero-wait memories.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_F, "alu_fetch");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_D, "alu_decode");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_E, "alu_execute");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_W, "alu_writeback");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_F, "alu_refetch");

    // 2. Memory instruction with 3 dmem wait cycles.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_D, "mem_decode");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_E, "mem_execute");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_M, "mem_enter");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_M, "mem_wait");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_W, "mem_writeback");

    // 5. Halt pulse in DECODE: instruction completes, then IDLE.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_F, "halt_fetch");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_D, "halt_decode");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_E, "halt_execute");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_W, "halt_writeback");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_IDLE, "halt_idle");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_IDLE, "halt_no_fetch");

    // 4. imem_ready arrives on the last allowed wait cycle: ready wins.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F, "late_fetch");
    for (int i = 0; i < 15; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F, "late_wait");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_D, "late_ready_wins");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_E, "late_execute");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_W, "late_writeback");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_IDLE, "late_idle");

    // 3. imem_ready never comes: ERROR after 16 FETCH cycles, run ignored.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_F, "to_fetch");
    for (int i = 0; i < 15; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_F, "to_wait");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_ERR, "to_error");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_ERR, "to_run_ignored");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, E_ERR, "to_sticky");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "to_reset");

    // Three ALU instructions, halt during the last one's decode.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_F, "perf_f1");
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_D, "perf_d");
      step(1'b0, 1'b0, (n == 2), 1'b1, 1'b1, 1'b0, E_E, "perf_e");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_W, "perf_w");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, (n == 2) ? E_IDLE : E_F, "perf_next");
    end
`ifdef CORE_SEQ_PERF_EN
    exp_cyc = CNT_W'(12);
    exp_ret = CNT_W'(3);
`else
    exp_cyc = {CNT_W{1'b0}};
    exp_ret = {CNT_W{1'b0}};
`endif
    check_cnt(cycle_cnt,   exp_cyc, "perf_cycle_cnt");
    check_cnt(instret_cnt, exp_ret, "perf_instret_cnt");

    // 6. Reset in the middle of MEMORY.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_F, "mrst_fetch");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_D, "mrst_decode");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_E, "mrst_execute");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_M, "mrst_memory");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_IDLE, "mrst_reset");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_IDLE, "mrst_idle");
    check_cnt(cycle_cnt,   {CNT_W{1'b0}}, "mrst_cycle_cnt");
    check_cnt(instret_cnt, {CNT_W{1'b0}}, "mrst_instret_cnt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
